// File: rtl/fb_pkg.sv
// Shared constants and types for the frame-buffer fetch path.
// Timing sets follow the video timing counter (active counts and last counts).
package fb_pkg;

    localparam int H_ACT_720   = 1280;
    localparam int V_ACT_720   = 720;
    localparam int H_LAST_720  = 1649;
    localparam int V_LAST_720  = 749;

    localparam int H_ACT_1080  = 1920;
    localparam int V_ACT_1080  = 1080;
    localparam int H_LAST_1080 = 2199;
    localparam int V_LAST_1080 = 1124;

    localparam int BURST_LEN_DEF  = 32;
    localparam int FIFO_DEPTH_DEF = 512;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        WAIT_ACK,
        DONE
    } fetch_state_t;

    // Frame restart: first pixel of the first vertical-blanking line.
    function automatic logic is_restart(input logic [31:0] vcount,
                                        input logic [31:0] hcount,
                                        input int unsigned v_act);
        return (vcount == 32'(v_act)) && (hcount == '0);
    endfunction

endpackage

// File: rtl/fetch_credit.sv
// Free-space credit counter for the display line FIFO.
// Saturates at FIFO_DEPTH; a pop while already full raises a sticky overrun.
module fetch_credit
    import fb_pkg::*;
#(
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
    parameter int BURST_LEN  = BURST_LEN_DEF,
    localparam int CW        = $clog2(FIFO_DEPTH) + 1
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_pop,
    input  logic          i_take,
    input  logic          i_load,
    output logic [CW-1:0] o_credits,
    output logic          o_overrun
);

    localparam logic [CW-1:0] DEPTH = CW'(FIFO_DEPTH);
    localparam logic [CW-1:0] BURST = CW'(BURST_LEN);

    logic [CW-1:0] r_credits;
    logic          r_overrun;
    logic [CW:0]   w_sum;

    // One extra bit so credits + pop can exceed DEPTH before saturation.
    always_comb begin
        w_sum = {1'b0, r_credits} + {{CW{1'b0}}, i_pop};
        if (i_take) begin
            w_sum = w_sum - {1'b0, BURST};
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_credits <= DEPTH;
            r_overrun <= 1'b0;
        end else if (i_load) begin
            r_credits <= DEPTH;
            r_overrun <= 1'b0;
        end else begin
            r_credits <= (w_sum > {1'b0, DEPTH}) ? DEPTH : w_sum[CW-1:0];
            if (i_pop && (r_credits == DEPTH)) begin
                r_overrun <= 1'b1;
            end
        end
    end

    assign o_credits = r_credits;
    assign o_overrun = r_overrun;

endmodule

// File: rtl/fb_fetch_sched.sv
// Frame-buffer read scheduler: issues burst reads that keep the line FIFO
// ahead of the display, walking the frame line by line from each restart.
module fb_fetch_sched
    import fb_pkg::*;
#(
    parameter int H_ACT       = H_ACT_720,
    parameter int V_ACT       = V_ACT_720,
    parameter int BURST_LEN   = BURST_LEN_DEF,
    parameter int FIFO_DEPTH  = FIFO_DEPTH_DEF,
    parameter int LINE_STRIDE = 2048,
    parameter int BASE_ADDR   = 0,
    parameter int ADDR_W      = 24
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              enable,
    input  logic [31:0]       Vert_Count,
    input  logic [31:0]       Horz_Count,
    input  logic              pix_pop,
    input  logic              rd_ack,
    output logic              rd_req,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              fifo_flush,
    output logic              frame_busy,
    output logic              overrun
);

    localparam int NBURST = H_ACT / BURST_LEN;
    localparam int BW     = $clog2(NBURST) + 1;
    localparam int LW     = $clog2(V_ACT) + 1;
    localparam int CW     = $clog2(FIFO_DEPTH) + 1;

    localparam logic [BW-1:0]     LAST_BURST = BW'(NBURST - 1);
    localparam logic [LW-1:0]     LAST_LINE  = LW'(V_ACT - 1);
    localparam logic [ADDR_W-1:0] A_BASE     = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] A_BURST    = ADDR_W'(BURST_LEN);
    localparam logic [ADDR_W-1:0] A_STRIDE   = ADDR_W'(LINE_STRIDE);
    localparam logic [CW-1:0]     C_BURST    = CW'(BURST_LEN);

    fetch_state_t      r_state;
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W-1:0] r_line_base;
    logic [BW-1:0]     r_burst_cnt;
    logic [LW-1:0]     r_line_cnt;
    logic              r_req;
    logic [ADDR_W-1:0] r_rd_addr;
    logic              r_flush;
    logic              r_busy;

    logic              w_restart;
    logic              w_start;
    logic              w_take;
    logic [CW-1:0]     w_credits;
    logic              w_overrun;

    assign w_restart = is_restart(Vert_Count, Horz_Count, V_ACT);
    assign w_start   = w_restart && enable && ((r_state == IDLE) || (r_state == DONE));
    assign w_take    = (r_state == WAIT_ACK) && rd_ack;

    fetch_credit #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .BURST_LEN  (BURST_LEN)
    ) u_credit (
        .i_clk     (clock),
        .i_rst     (reset),
        .i_pop     (pix_pop),
        .i_take    (w_take),
        .i_load    (w_start),
        .o_credits (w_credits),
        .o_overrun (w_overrun)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state     <= IDLE;
            r_addr      <= A_BASE;
            r_line_base <= A_BASE;
            r_burst_cnt <= '0;
            r_line_cnt  <= '0;
            r_req       <= 1'b0;
            r_rd_addr   <= A_BASE;
            r_flush     <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_flush <= 1'b0;
            if (w_start) begin
                r_flush     <= 1'b1;
                r_addr      <= A_BASE;
                r_line_base <= A_BASE;
                r_burst_cnt <= '0;
                r_line_cnt  <= '0;
                r_state     <= FETCH;
                r_busy      <= 1'b1;
            end else begin
                case (r_state)
                    IDLE: ;
                    FETCH: begin
                        if (!enable) begin
                            r_state <= IDLE;
                            r_busy  <= 1'b0;
                        end else if (w_credits >= C_BURST) begin
                            r_req     <= 1'b1;
                            r_rd_addr <= r_addr;
                            r_state   <= WAIT_ACK;
                        end
                    end
                    WAIT_ACK: begin
                        if (rd_ack) begin
                            r_req <= 1'b0;
                            if (r_burst_cnt == LAST_BURST) begin
                                r_burst_cnt <= '0;
                                r_line_cnt  <= r_line_cnt + 1'b1;
                                r_line_base <= r_line_base + A_STRIDE;
                                r_addr      <= r_line_base + A_STRIDE;
                                if (r_line_cnt == LAST_LINE) begin
                                    r_state <= DONE;
                                    r_busy  <= 1'b0;
                                end else begin
                                    r_state <= FETCH;
                                end
                            end else begin
                                r_burst_cnt <= r_burst_cnt + 1'b1;
                                r_addr      <= r_addr + A_BURST;
                                r_state     <= FETCH;
                            end
                        end
                    end
                    // w_start already covered enable=1; a restart here means disabled.
                    DONE: begin
                        if (w_restart) begin
                            r_state <= IDLE;
                        end
                    end
                    default: begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign rd_req     = r_req;
    assign rd_addr    = r_rd_addr;
    assign fifo_flush = r_flush;
    assign frame_busy = r_busy;
    assign overrun    = w_overrun;

endmodule
